// File: rtl/cmd_frame_master_pkg.sv
// cmd_frame_master_pkg: shared command codes, frame constants and FSM state type
package cmd_frame_master_pkg;
  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_REQ = 8'h05;
  localparam logic [7:0] CMD_COUNT    = 8'h06;
  localparam logic [7:0] CMD_CONST    = 8'h07;
  localparam int CMD_BYTES  = 5;
  localparam int DATA_BYTES = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_SEND,
    S_TX_WAIT_BUSY,
    S_TX_WAIT_IDLE,
    S_RX,
    S_DONE
  } state_t;
endpackage

// File: rtl/cmd_frame_master.sv
// cmd_frame_master: sends a 5-byte command frame over a byte transmitter, collects RSP_BYTES response bytes into a 32-bit word with inter-byte timeout
module cmd_frame_master
  import cmd_frame_master_pkg::*;
#(
  parameter int RSP_BYTES      = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [31:0] cmd_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [39:0] shift, shift_n;
  logic [2:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [TW-1:0] idle, idle_n;
  logic [31:0] acc, acc_n, rsp_q, rsp_n;
  logic tflag, tflag_n;
  assign cmd_ready   = state == S_IDLE;
  assign tx_data     = shift[39:32];
  assign rsp_valid   = state == S_DONE;
  assign rsp_timeout = rsp_valid & tflag;
  assign rsp_data    = rsp_q;
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    tx_cnt_n = tx_cnt;
    rx_cnt_n = rx_cnt;
    idle_n   = idle;
    acc_n    = acc;
    rsp_n    = rsp_q;
    tflag_n  = tflag;
    tx_start = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        state_n  = S_TX_SEND;
        shift_n  = {cmd_code, cmd_data};
        tx_cnt_n = '0;
        rx_cnt_n = '0;
        acc_n    = '0;
        tflag_n  = 1'b0;
      end
      S_TX_SEND: if (tx_ready) begin
        tx_start = 1'b1;
        state_n  = S_TX_WAIT_BUSY;
      end
      S_TX_WAIT_BUSY: state_n = tx_ready ? S_TX_WAIT_BUSY : S_TX_WAIT_IDLE;
      S_TX_WAIT_IDLE: if (tx_ready) begin
        shift_n  = {shift[31:0], 8'h00};
        tx_cnt_n = tx_cnt + 3'd1;
        idle_n   = '0;
        state_n  = (tx_cnt == 3'(CMD_BYTES - 1)) ? S_RX : S_TX_SEND;
      end
      S_RX: if (rx_valid) begin
        acc_n    = (rx_cnt < 3'(DATA_BYTES)) ? {acc[23:0], rx_data} : acc;
        rx_cnt_n = rx_cnt + 3'd1;
        idle_n   = '0;
        state_n  = (rx_cnt == 3'(RSP_BYTES - 1)) ? S_DONE : S_RX;
        rsp_n    = (rx_cnt == 3'(RSP_BYTES - 1)) ? acc_n : rsp_q;
      end else if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n = S_DONE;
        tflag_n = 1'b1;
        rsp_n   = acc;
      end else begin
        idle_n = idle + TW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      shift  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      idle   <= '0;
      acc    <= '0;
      rsp_q  <= '0;
      tflag  <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      tx_cnt <= tx_cnt_n;
      rx_cnt <= rx_cnt_n;
      idle   <= idle_n;
      acc    <= acc_n;
      rsp_q  <= rsp_n;
      tflag  <= tflag_n;
    end
  end
endmodule

// File: tb/tb_cmd_frame_master.sv
// tb_cmd_frame_master: scoreboard bench with transmitter/responder models and randomized frames
module tb_cmd_frame_master;
  import cmd_frame_master_pkg::*;
  localparam int RB = 5;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, tx_start, tx_ready, rx_valid, rsp_valid, rsp_timeout;
  logic [7:0] cmd_code, tx_data, rx_data;
  logic [31:0] cmd_data, rsp_data;
  int total = 0;
  int bad = 0;
  int line_cnt = 0;
  int done_cnt = 0;
  int abort_gen = 0;
  bit tx_active = 1'b0;
  logic [7:0] exp_tx[$];
  logic [32:0] exp_rsp[$];
  logic [31:0] last_rsp = '0;
  logic [7:0] rb[8];
  always #5 clk = ~clk;
  cmd_frame_master #(.RSP_BYTES(RB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        automatic logic [7:0] b = tx_data;
        automatic int g = abort_gen;
        tx_active = 1'b1;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          if (g == abort_gen) chk("tx_hold_lag", tx_data, b);
        end
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          if (g == abort_gen) chk("tx_hold_busy", tx_data, b);
        end
        tx_ready = 1'b1;
        done_cnt++;
        tx_active = 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    if (reset) last_rsp = '0;
    else begin
      if (tx_start) begin
        line_cnt++;
        if (exp_tx.size() == 0) chk("tx_extra", tx_start, 0);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (rsp_valid) begin
        chk("cmd_ready_done", cmd_ready, 0);
        if (exp_rsp.size() == 0) chk("rsp_extra", rsp_valid, 0);
        else begin
          automatic logic [32:0] e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e[31:0]);
          chk("rsp_timeout", rsp_timeout, e[32]);
        end
        last_rsp = rsp_data;
      end else begin
        chk("rsp_timeout_idle", rsp_timeout, 0);
        chk("rsp_hold", rsp_data, last_rsp);
      end
    end
  end
  task automatic issue(input logic [7:0] code, input logic [31:0] data, input bit b2b);
    int w = 0;
    exp_tx.push_back(code);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(data[8*i +: 8]);
    cmd_valid = 1'b1;
    cmd_code = code;
    cmd_data = data;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_code = 8'($urandom);
    cmd_data = $urandom;
    chk("cmd_ready_busy", cmd_ready, 0);
    if (b2b) chk("b2b_accept_wait", w, 1);
  endtask
  task automatic frame(input logic [7:0] code, input logic [31:0] data, input int nsend, input bit noise, input bit b2b);
    int base, lbase, g, n;
    logic [31:0] acc;
    if (!b2b) repeat ($urandom_range(1, 4)) @(negedge clk);
    base = done_cnt;
    lbase = line_cnt;
    issue(code, data, b2b);
    g = 0;
    while (done_cnt < base + CMD_BYTES && g < 5000) begin
      if (noise) begin
        rx_valid = ($urandom % 3) == 0;
        rx_data = 8'($urandom);
        cmd_valid = ($urandom % 4) == 0;
        cmd_code = 8'($urandom);
        cmd_data = $urandom;
      end
      @(negedge clk);
      g++;
    end
    rx_valid = 1'b0;
    cmd_valid = 1'b0;
    if (g >= 5000) chk("tx_phase_timeout", done_cnt - base, CMD_BYTES);
    @(negedge clk);
    chk("tx_pulses", line_cnt - lbase, CMD_BYTES);
    acc = '0;
    for (int i = 0; i < nsend && i < 4; i++) acc = (acc << 8) | 32'(rb[i]);
    exp_rsp.push_back({nsend < RB, acc});
    n = 0;
    for (int i = 0; i < nsend; i++) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      rx_valid = 1'b1;
      rx_data = rb[i];
      @(negedge clk);
      rx_valid = 1'b0;
    end
    n = 1;
    while (!rsp_valid && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    if (nsend > 0) chk("rsp_latency", n, (nsend == RB) ? 1 : TO + 1);
    else chk("rsp_seen", rsp_valid, 1);
  endtask
  task automatic abort_frame(input logic [7:0] code, input logic [31:0] data);
    int lbase, g;
    repeat (3) @(negedge clk);
    lbase = line_cnt;
    issue(code, data, 1'b0);
    g = 0;
    while (line_cnt < lbase + 3 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("abort_reach", line_cnt - lbase, 3);
    abort_gen++;
    reset = 1'b1;
    @(negedge clk);
    exp_tx.delete();
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_tx_data", tx_data, 0);
    @(negedge clk);
    reset = 1'b0;
    g = 0;
    while (tx_active && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
  initial begin
    logic [7:0] codes[7];
    codes = '{CMD_ADDR, CMD_LOAD, CMD_WRITE, CMD_READ, CMD_READ_REQ, CMD_COUNT, CMD_CONST};
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_code = '0;
    cmd_data = '0;
    rx_valid = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    reset = 1'b0;
    rb = '{8'h00, 8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(CMD_COUNT, 32'h0, RB, 1'b0, 1'b0);
    frame(CMD_ADDR, 32'h0000_0104, RB, 1'b0, 1'b1);
    rb[0] = 8'hAB;
    frame(CMD_READ, 32'h1234_5678, 1, 1'b0, 1'b0);
    rb = '{8'h5A, 8'hC3, 8'h7E, 8'h11, 8'hF0, 8'h00, 8'h00, 8'h00};
    frame(CMD_WRITE, 32'hDEAD_BEEF, RB, 1'b1, 1'b0);
    frame(CMD_LOAD, 32'hCAFE_0001, 0, 1'b0, 1'b1);
    abort_frame(CMD_WRITE, 32'hA5A5_5A5A);
    rb = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    frame(CMD_CONST, 32'h0, RB, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      automatic int ns = (($urandom % 5) == 0) ? int'($urandom_range(0, RB - 1)) : RB;
      for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
      frame(codes[$urandom_range(0, 6)], $urandom, ns, 1'($urandom % 2), 1'($urandom % 2));
    end
    repeat (5) @(negedge clk);
    chk("tx_queue_left", exp_tx.size(), 0);
    chk("rsp_queue_left", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
